// File: rtl/tlp_xcvr_pkg.sv
// rtl/tlp_xcvr_pkg.sv - shared types, constants and action builders for the TLP transceiver
// Purpose: action word passed from the receive block to tlp_send, plus the
//          completion header layouts used by the CplD formatter.
// Ports:   none (package).
package tlp_xcvr_pkg;

  typedef logic [3:0]  ExtChan;
  typedef logic [15:0] BusID;
  typedef logic [7:0]  Tag;
  typedef logic [31:0] uint32;

  typedef enum logic [1:0] {
    ACT_NOP   = 2'd0,
    ACT_READ  = 2'd1,
    ACT_WRITE = 2'd2
  } ActType;

  typedef struct packed {
    ActType typ;
    ExtChan chan;
    BusID   reqID;
    Tag     tag;
    uint32  data;
  } Action;

  localparam logic [2:0] FMT_3DW_DATA = 3'b010;
  localparam logic [4:0] TYP_CPL      = 5'b01010;

  // DW0 of the completion header; TC, attributes and flags are all zero.
  typedef struct packed {
    logic [2:0]  fmt;
    logic [4:0]  typ;
    logic [13:0] tcAttr;
    logic [9:0]  length;
  } CplHdr0;

  typedef struct packed {
    BusID        completerId;
    logic [2:0]  status;
    logic        bcm;
    logic [11:0] byteCount;
  } CplHdr1;

  typedef struct packed {
    BusID       reqId;
    Tag         tag;
    logic       rsvd;
    logic [6:0] lowerAddr;
  } CplHdr2;

  function automatic Action genRegRead(ExtChan chan, BusID reqID, Tag tag);
    Action a;
    a       = '0;
    a.typ   = ACT_READ;
    a.chan  = chan;
    a.reqID = reqID;
    a.tag   = tag;
    return a;
  endfunction

  function automatic Action genRegWrite(ExtChan chan, uint32 data);
    Action a;
    a      = '0;
    a.typ  = ACT_WRITE;
    a.chan = chan;
    a.data = data;
    return a;
  endfunction

endpackage

// File: rtl/tlp_cpl_fmt.sv
// rtl/tlp_cpl_fmt.sv - registered 3-beat CplD formatter for the 64-bit TX stream
// Purpose: on start, emits SOP header beat, requester/lower-address beat and
//          the data beat (EOP), each held stable until txReady is seen.
// Ports:   pcieClk_in/pcieRstN_in clock and async active-low reset;
//          start        load beat 0 (only honoured while idle);
//          cfgBusDev    {bus, dev} for the completer ID;
//          reqId/tag/lowerAddr/rdData  completion fields, held by the caller;
//          txData/txValid/txReady/txSOP/txEOP  TX stream.
module tlp_cpl_fmt
  import tlp_xcvr_pkg::*;
(
  input  logic        pcieClk_in,
  input  logic        pcieRstN_in,
  input  logic        start,
  input  logic [12:0] cfgBusDev,
  input  BusID        reqId,
  input  Tag          tag,
  input  logic [6:0]  lowerAddr,
  input  uint32       rdData,
  output logic [63:0] txData,
  output logic        txValid,
  input  logic        txReady,
  output logic        txSOP,
  output logic        txEOP
);

  CplHdr0     hdr0;
  CplHdr1     hdr1;
  CplHdr2     hdr2;
  logic [1:0] beat;

  always_comb begin
    hdr0             = '0;
    hdr0.fmt         = FMT_3DW_DATA;
    hdr0.typ         = TYP_CPL;
    hdr0.length      = 10'd1;
    hdr1             = '0;
    hdr1.completerId = {cfgBusDev, 3'b000};
    hdr1.byteCount   = 12'd4;
    hdr2             = '0;
    hdr2.reqId       = reqId;
    hdr2.tag         = tag;
    hdr2.lowerAddr   = lowerAddr;
  end

  // Lower address is always QW aligned, so the payload never shares the
  // header's second beat and always lands in DW0 of the third beat.
  always_ff @(posedge pcieClk_in or negedge pcieRstN_in) begin
    if (!pcieRstN_in) begin
      txData  <= '0;
      txValid <= 1'b0;
      txSOP   <= 1'b0;
      txEOP   <= 1'b0;
      beat    <= 2'd0;
    end else if (txValid && txReady) begin
      unique case (beat)
        2'd0: begin
          txData <= {32'h0, hdr2};
          txSOP  <= 1'b0;
          beat   <= 2'd1;
        end
        2'd1: begin
          txData <= {32'h0, rdData};
          txEOP  <= 1'b1;
          beat   <= 2'd2;
        end
        default: begin
          txData  <= '0;
          txValid <= 1'b0;
          txEOP   <= 1'b0;
          beat    <= 2'd0;
        end
      endcase
    end else if (!txValid && start) begin
      txData  <= {hdr1, hdr0};
      txValid <= 1'b1;
      txSOP   <= 1'b1;
      txEOP   <= 1'b0;
      beat    <= 2'd0;
    end
  end

endmodule

// File: rtl/tlp_send.sv
// rtl/tlp_send.sv - transmit half of the TLP transceiver: action FSM
// Purpose: consumes actions; writes strobe the register port, reads fetch a
//          value (or time out) and return a 3DW CplD on the TX stream.
// Ports:   pcieClk_in/pcieRstN_in clock and async active-low reset;
//          cfgBusDev_in {bus, dev}; actData/actValid/actReady action input;
//          txData/txValid/txReady/txSOP/txEOP TX stream;
//          regChan/regWrValid/regWrData/regRdReq/regRdData/regRdValid
//          application register port.
module tlp_send
  import tlp_xcvr_pkg::*;
#(
  parameter int          RD_TIMEOUT   = 255,
  parameter logic [31:0] TIMEOUT_DATA = 32'hDEADBEEF
)(
  input  logic        pcieClk_in,
  input  logic        pcieRstN_in,
  input  logic [12:0] cfgBusDev_in,
  input  Action       actData_in,
  input  logic        actValid_in,
  output logic        actReady_out,
  output logic [63:0] txData_out,
  output logic        txValid_out,
  input  logic        txReady_in,
  output logic        txSOP_out,
  output logic        txEOP_out,
  output ExtChan      regChan_out,
  output logic        regWrValid_out,
  output logic [31:0] regWrData_out,
  output logic        regRdReq_out,
  input  logic [31:0] regRdData_in,
  input  logic        regRdValid_in
);

  localparam int CW = (RD_TIMEOUT < 2) ? 1 : $clog2(RD_TIMEOUT + 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_WR,
    S_RD_WAIT,
    S_CPL0,
    S_CPL1,
    S_CPL2
  } SendState;

  SendState      state, stateNext;
  logic [CW-1:0] rdCnt;
  BusID          reqIdQ;
  Tag            tagQ;
  uint32         rdDataQ;
  logic          accept, isRead, isWrite, rdDone, timedOut, beatTaken;

  always_comb begin
    stateNext = state;
    accept    = 1'b0;
    rdDone    = 1'b0;
    isRead    = (actData_in.typ == ACT_READ);
    isWrite   = (actData_in.typ == ACT_WRITE);
    timedOut  = (rdCnt == CW'(RD_TIMEOUT));
    beatTaken = txValid_out && txReady_in;
    unique case (state)
      S_IDLE: begin
        if (actValid_in && actReady_out) begin
          accept = 1'b1;
          if (isRead) begin
            stateNext = S_RD_WAIT;
          end else if (isWrite) begin
            stateNext = S_WR;
          end
        end
      end
      S_WR:      stateNext = S_IDLE;
      S_RD_WAIT: begin
        if (regRdValid_in || timedOut) begin
          rdDone    = 1'b1;
          stateNext = S_CPL0;
        end
      end
      S_CPL0:    if (beatTaken) stateNext = S_CPL1;
      S_CPL1:    if (beatTaken) stateNext = S_CPL2;
      S_CPL2:    if (beatTaken) stateNext = S_IDLE;
      default:   stateNext = S_IDLE;
    endcase
  end

  always_ff @(posedge pcieClk_in or negedge pcieRstN_in) begin
    if (!pcieRstN_in) begin
      state          <= S_IDLE;
      rdCnt          <= '0;
      actReady_out   <= 1'b0;
      regChan_out    <= '0;
      regWrValid_out <= 1'b0;
      regWrData_out  <= '0;
      regRdReq_out   <= 1'b0;
      reqIdQ         <= '0;
      tagQ           <= '0;
      rdDataQ        <= '0;
    end else begin
      state          <= stateNext;
      actReady_out   <= (stateNext == S_IDLE);
      regWrValid_out <= accept && isWrite;
      regRdReq_out   <= accept && isRead;
      if (accept && (isRead || isWrite)) regChan_out <= actData_in.chan;
      if (accept && isWrite) regWrData_out <= actData_in.data;
      // The counter holds during the request cycle, so the window is
      // RD_TIMEOUT cycles measured from the first cycle data could arrive.
      if (accept && isRead) begin
        reqIdQ <= actData_in.reqID;
        tagQ   <= actData_in.tag;
        rdCnt  <= '0;
      end else if (state == S_RD_WAIT && !regRdReq_out && !timedOut) begin
        rdCnt <= rdCnt + CW'(1);
      end
      // Real data wins over a timeout landing on the same cycle.
      if (rdDone) rdDataQ <= regRdValid_in ? regRdData_in : TIMEOUT_DATA;
    end
  end

  tlp_cpl_fmt u_fmt (
    .pcieClk_in  (pcieClk_in),
    .pcieRstN_in (pcieRstN_in),
    .start       (rdDone),
    .cfgBusDev   (cfgBusDev_in),
    .reqId       (reqIdQ),
    .tag         (tagQ),
    .lowerAddr   ({regChan_out, 3'b000}),
    .rdData      (rdDataQ),
    .txData      (txData_out),
    .txValid     (txValid_out),
    .txReady     (txReady_in),
    .txSOP       (txSOP_out),
    .txEOP       (txEOP_out)
  );

endmodule

// File: tb/tb_tlp_send.sv
// tb/tb_tlp_send.sv - directed self-checking bench for tlp_send
// Purpose: drives write/read/timeout/stall/back-to-back/reset scenarios and
//          checks register strobes and CplD beats against hand-computed values.
// Ports:   none (top-level bench).
module tb_tlp_send;
  import tlp_xcvr_pkg::*;

  localparam int RD_TO = 255;

  logic        pcieClk_in;
  logic        pcieRstN_in;
  logic [12:0] cfgBusDev_in;
  Action       actData_in;
  logic        actValid_in;
  logic        actReady_out;
  logic [63:0] txData_out;
  logic        txValid_out;
  logic        txReady_in;
  logic        txSOP_out;
  logic        txEOP_out;
  ExtChan      regChan_out;
  logic        regWrValid_out;
  logic [31:0] regWrData_out;
  logic        regRdReq_out;
  logic [31:0] regRdData_in;
  logic        regRdValid_in;

  int nCmp = 0;
  int nErr = 0;

  tlp_send #(.RD_TIMEOUT(RD_TO), .TIMEOUT_DATA(32'hDEADBEEF)) dut (
    .pcieClk_in     (pcieClk_in),
    .pcieRstN_in    (pcieRstN_in),
    .cfgBusDev_in   (cfgBusDev_in),
    .actData_in     (actData_in),
    .actValid_in    (actValid_in),
    .actReady_out   (actReady_out),
    .txData_out     (txData_out),
    .txValid_out    (txValid_out),
    .txReady_in     (txReady_in),
    .txSOP_out      (txSOP_out),
    .txEOP_out      (txEOP_out),
    .regChan_out    (regChan_out),
    .regWrValid_out (regWrValid_out),
    .regWrData_out  (regWrData_out),
    .regRdReq_out   (regRdReq_out),
    .regRdData_in   (regRdData_in),
    .regRdValid_in  (regRdValid_in)
  );

  initial pcieClk_in = 1'b0;
  always #4 pcieClk_in = ~pcieClk_in;

  task automatic step();
    @(posedge pcieClk_in);
    #1;
  endtask

  task automatic chk(input string tagName, input logic [63:0] obs, input logic [63:0] exp);
    nCmp++;
    assert (obs === exp) else begin
      nErr++;
      $error("FAIL %s: observed %h expected %h", tagName, obs, exp);
    end
  endtask

  initial begin
    logic [63:0] expBeat[3];
    logic [5:0]  pat;
    Action       bad;
    Action       seq[3];
    int          cnt, nb, pi, idx, nWr, nRq, eopEdge;
    int          accEdge[3];
    int          wrEdge[2];
    logic [31:0] wrData[2];
    logic        pend, acc;

    pcieRstN_in   = 1'b0;
    cfgBusDev_in  = 13'h0008;
    actData_in    = '0;
    actValid_in   = 1'b0;
    txReady_in    = 1'b1;
    regRdData_in  = '0;
    regRdValid_in = 1'b0;
    step();
    step();
    chk("rst_txValid", 64'(txValid_out), 64'd0);
    chk("rst_actReady", 64'(actReady_out), 64'd0);
    chk("rst_regWrValid", 64'(regWrValid_out), 64'd0);
    chk("rst_regRdReq", 64'(regRdReq_out), 64'd0);
    chk("rst_txData", txData_out, 64'd0);
    chk("rst_sopeop", 64'({txSOP_out, txEOP_out}), 64'd0);
    pcieRstN_in = 1'b1;
    step();
    chk("idle_actReady", 64'(actReady_out), 64'd1);

    // Register write
    actData_in  = genRegWrite(4'h5, 32'h12345678);
    actValid_in = 1'b1;
    step();
    actValid_in = 1'b0;
    chk("wr_strobe", 64'(regWrValid_out), 64'd1);
    chk("wr_chan", 64'(regChan_out), 64'd5);
    chk("wr_data", 64'(regWrData_out), 64'h12345678);
    chk("wr_actReady_low", 64'(actReady_out), 64'd0);
    chk("wr_no_tx", 64'(txValid_out), 64'd0);
    step();
    chk("wr_strobe_1cyc", 64'(regWrValid_out), 64'd0);
    chk("wr_actReady_back", 64'(actReady_out), 64'd1);

    // NOP and unknown type are dropped
    actData_in  = '0;
    actValid_in = 1'b1;
    step();
    bad         = genRegWrite(4'h9, 32'h1);
    bad.typ     = ActType'(2'd3);
    actData_in  = bad;
    step();
    actValid_in = 1'b0;
    chk("nop_actReady", 64'(actReady_out), 64'd1);
    chk("nop_no_strobe", 64'({regWrValid_out, regRdReq_out}), 64'd0);

    // Stray read valid in idle is ignored
    regRdValid_in = 1'b1;
    step();
    regRdValid_in = 1'b0;
    step();
    chk("stray_rdvalid", 64'(txValid_out), 64'd0);

    // Read, data two cycles after request
    expBeat[0] = 64'h00400004_4A000001;
    expBeat[1] = 64'h00000000_01002A18;
    expBeat[2] = 64'h00000000_CAFEF00D;
    actData_in  = genRegRead(4'h3, 16'h0100, 8'h2A);
    actValid_in = 1'b1;
    step();
    actValid_in = 1'b0;
    chk("rd_req", 64'(regRdReq_out), 64'd1);
    chk("rd_chan", 64'(regChan_out), 64'd3);
    step();
    chk("rd_req_1cyc", 64'(regRdReq_out), 64'd0);
    step();
    regRdValid_in = 1'b1;
    regRdData_in  = 32'hCAFEF00D;
    step();
    regRdValid_in = 1'b0;
    chk("rd_b0_valid", 64'(txValid_out), 64'd1);
    chk("rd_b0_data", txData_out, expBeat[0]);
    chk("rd_b0_sopeop", 64'({txSOP_out, txEOP_out}), 64'b10);
    step();
    chk("rd_b1_data", txData_out, expBeat[1]);
    chk("rd_b1_sopeop", 64'({txSOP_out, txEOP_out}), 64'b00);
    step();
    chk("rd_b2_data", txData_out, expBeat[2]);
    chk("rd_b2_sopeop", 64'({txSOP_out, txEOP_out}), 64'b01);
    chk("rd_b2_actReady", 64'(actReady_out), 64'd0);
    step();
    chk("rd_end_valid", 64'(txValid_out), 64'd0);
    chk("rd_end_actReady", 64'(actReady_out), 64'd1);

    // Same read with backpressure 1,0,0,1,0,1
    pat         = 6'b101001;
    actData_in  = genRegRead(4'h3, 16'h0100, 8'h2A);
    actValid_in = 1'b1;
    step();
    actValid_in = 1'b0;
    step();
    regRdValid_in = 1'b1;
    step();
    regRdValid_in = 1'b0;
    nb = 0;
    pi = 0;
    cnt = 0;
    while (nb < 3 && cnt < 20) begin
      txReady_in = (pi < 6) ? pat[pi] : 1'b1;
      pi++;
      chk($sformatf("st_valid_%0d", cnt), 64'(txValid_out), 64'd1);
      chk($sformatf("st_data_%0d", cnt), txData_out, expBeat[nb]);
      chk($sformatf("st_sop_%0d", cnt), 64'(txSOP_out), 64'(nb == 0));
      chk($sformatf("st_eop_%0d", cnt), 64'(txEOP_out), 64'(nb == 2));
      chk($sformatf("st_actReady_%0d", cnt), 64'(actReady_out), 64'd0);
      if (txReady_in) nb++;
      step();
      cnt++;
    end
    txReady_in = 1'b1;
    chk("st_beats", 64'(nb), 64'd3);
    chk("st_cycles", 64'(cnt), 64'd6);
    chk("st_end_valid", 64'(txValid_out), 64'd0);
    chk("st_end_actReady", 64'(actReady_out), 64'd1);

    // Read timeout
    actData_in  = genRegRead(4'h2, 16'h0A0B, 8'h05);
    actValid_in = 1'b1;
    step();
    actValid_in = 1'b0;
    chk("to_req", 64'(regRdReq_out), 64'd1);
    cnt = 0;
    while (!txValid_out && cnt < 400) begin
      step();
      cnt++;
    end
    chk("to_sop_latency", 64'(cnt), 64'(RD_TO + 2));
    chk("to_b0_data", txData_out, 64'h00400004_4A000001);
    chk("to_b0_sop", 64'(txSOP_out), 64'd1);
    step();
    chk("to_b1_data", txData_out, 64'h00000000_0A0B0510);
    step();
    chk("to_b2_data", txData_out, 64'h00000000_DEADBEEF);
    chk("to_b2_eop", 64'(txEOP_out), 64'd1);
    step();
    chk("to_end_valid", 64'(txValid_out), 64'd0);

    // Back-to-back write, read, write with actValid held high
    seq[0] = genRegWrite(4'h1, 32'hAAAA0001);
    seq[1] = genRegRead(4'h2, 16'h0055, 8'h07);
    seq[2] = genRegWrite(4'h6, 32'hBBBB0002);
    regRdData_in = 32'h13579BDF;
    idx = 0;
    nWr = 0;
    nRq = 0;
    eopEdge = -1;
    pend = 1'b0;
    accEdge[0] = -1; accEdge[1] = -1; accEdge[2] = -1;
    wrEdge[0] = -1; wrEdge[1] = -1;
    wrData[0] = '0; wrData[1] = '0;
    actData_in  = seq[0];
    actValid_in = 1'b1;
    for (int t = 0; t < 20; t++) begin
      regRdValid_in = pend;
      pend = regRdReq_out;
      if (regRdReq_out) nRq++;
      if (regWrValid_out) begin
        if (nWr < 2) begin
          wrEdge[nWr] = t;
          wrData[nWr] = regWrData_out;
        end
        nWr++;
      end
      if (txValid_out && txReady_in && txEOP_out) eopEdge = t + 1;
      acc = actValid_in && actReady_out;
      step();
      if (acc) begin
        if (idx < 3) accEdge[idx] = t + 1;
        idx++;
        if (idx < 3) actData_in = seq[idx];
        else actValid_in = 1'b0;
      end
    end
    actValid_in   = 1'b0;
    regRdValid_in = 1'b0;
    chk("b2b_accepts", 64'(idx), 64'd3);
    chk("b2b_gap_wr_rd", 64'(accEdge[1] - accEdge[0]), 64'd2);
    chk("b2b_gap_rd_wr", 64'(accEdge[2] - accEdge[1]), 64'd6);
    chk("b2b_nwr", 64'(nWr), 64'd2);
    chk("b2b_nreq", 64'(nRq), 64'd1);
    chk("b2b_wr0_data", 64'(wrData[0]), 64'hAAAA0001);
    chk("b2b_wr1_data", 64'(wrData[1]), 64'hBBBB0002);
    chk("b2b_wr1_after_eop", 64'(wrEdge[1] - eopEdge), 64'd1);

    // Reset during beat 1, then a fresh read
    actData_in  = genRegRead(4'h7, 16'h0203, 8'h11);
    actValid_in = 1'b1;
    step();
    actValid_in = 1'b0;
    step();
    regRdValid_in = 1'b1;
    regRdData_in  = 32'h55AA55AA;
    step();
    regRdValid_in = 1'b0;
    step();
    chk("mid_b1_present", 64'({txValid_out, txSOP_out}), 64'b10);
    #1 pcieRstN_in = 1'b0;
    #1;
    chk("mid_rst_valid", 64'(txValid_out), 64'd0);
    chk("mid_rst_data", txData_out, 64'd0);
    step();
    pcieRstN_in = 1'b1;
    step();
    chk("mid_post_actReady", 64'(actReady_out), 64'd1);
    chk("mid_post_valid", 64'(txValid_out), 64'd0);
    cfgBusDev_in = 13'h0123;
    actData_in   = genRegRead(4'h7, 16'h0203, 8'h11);
    actValid_in  = 1'b1;
    step();
    actValid_in = 1'b0;
    step();
    regRdValid_in = 1'b1;
    regRdData_in  = 32'h0BADF00D;
    step();
    regRdValid_in = 1'b0;
    chk("fresh_b0", txData_out, 64'h09180004_4A000001);
    chk("fresh_b0_sop", 64'(txSOP_out), 64'd1);
    step();
    chk("fresh_b1", txData_out, 64'h00000000_02031138);
    step();
    chk("fresh_b2", txData_out, 64'h00000000_0BADF00D);
    chk("fresh_b2_eop", 64'(txEOP_out), 64'd1);
    step();
    chk("fresh_end_valid", 64'(txValid_out), 64'd0);
    chk("fresh_end_actReady", 64'(actReady_out), 64'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCmp, nErr);
    $finish;
  end

endmodule
